key_matrix_scan: RTL and testbench

Row-scanning front end for the 4x6 key matrix. Drives one row low at a time on `key_out` and samples the six column lines on `key_in`. It debounces the result over whole scan frames and emits a single-cycle `key_valid` pulse with a 5-bit key code. It sits directly upstream of the key-decode / 7-segment stage, which consumes `key_code` and `key_valid`.

---
 rtl/key_matrix_scan.sv | 227 ++++++++++++++++++++++
 tb/tb_key_matrix_scan.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_matrix_scan.sv
// Purpose : row-scanning 4x6 key matrix front end with frame-level debounce.
// Latency : key_valid/key_code/key_held update the cycle after the frame-end
//           sample of the deciding frame; one frame = 4*SCAN_DIV cycles.
// Backpressure: none; key_valid is a single-cycle pulse the consumer must take.
// Ports   : clk, rst (sync, active high); key_in[5:0] active-low columns
//           (async); key_out[3:0] active-low one-hot row drive; key_code[4:0]
//           = row*6+col of last accepted key; key_valid press pulse; key_held
//           level from press acceptance until release acceptance.
module key_matrix_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] key_in,
  output logic [3:0] key_out,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [3:0]       DEB      = 4'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_CHK,
    S_HELD,
    S_REL_CHK
  } state_t;

  // Two-flop synchronizer; reset to all-ones so no key looks closed.
  logic [5:0] sync1_q;
  logic [5:0] col_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '1;
      col_s_q <= '1;
    end else begin
      sync1_q <= key_in;
      col_s_q <= sync1_q;
    end
  end

  // Dwell divider and row pointer.
  logic [DIV_W-1:0] div_q;
  logic [1:0]       row_q;
  logic             sample;
  logic             frame_end;

  assign sample    = (div_q == DIV_LAST);
  assign frame_end = sample && (row_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      row_q <= 2'd0;
    end else if (sample) begin
      div_q <= '0;
      row_q <= row_q + 2'd1;
    end else begin
      div_q <= div_q + DIV_ONE;
    end
  end

  assign key_out = ~(4'b0001 << row_q);

  // Lowest closed column on the current row.
  logic       col_hit;
  logic [2:0] col_idx;
  logic [4:0] row_code;

  always_comb begin
    col_hit = 1'b0;
    col_idx = 3'd0;
    for (int c = 5; c >= 0; c--) begin
      if (!col_s_q[c]) begin
        col_hit = 1'b1;
        col_idx = 3'(c);
      end
    end
  end

  assign row_code = 5'(row_q) * 5'd6 + 5'(col_idx);

  // Per-frame capture: first closure wins, since rows are visited in order
  // and the column search is lowest-first, this yields the lowest code.
  logic       found_q;
  logic [4:0] found_code_q;
  logic       res_hit;
  logic [4:0] res_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      found_q      <= 1'b0;
      found_code_q <= 5'd0;
    end else if (sample) begin
      if (row_q == 2'd3) begin
        found_q      <= 1'b0;
        found_code_q <= 5'd0;
      end else if (!found_q && col_hit) begin
        found_q      <= 1'b1;
        found_code_q <= row_code;
      end
    end
  end

  // Frame result, valid only when frame_end is high (row-3 sample included).
  assign res_hit  = found_q | col_hit;
  assign res_code = found_q ? found_code_q : row_code;

  // Debounce FSM, advanced only at frame end.
  state_t     state_q, state_d;
  logic [3:0] stab_q, stab_d;
  logic [4:0] cand_q, cand_d;
  logic [4:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       held_q, held_d;
  logic [3:0] stab_inc;

  assign stab_inc = stab_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      stab_q  <= 4'd0;
      cand_q  <= 5'd0;
      code_q  <= 5'd0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    cand_d  = cand_q;
    code_d  = code_q;
    held_d  = held_q;
    valid_d = 1'b0;
    if (frame_end) begin
      case (state_q)
        S_IDLE: begin
          if (res_hit) begin
            cand_d = res_code;
            if (DEB == 4'd1) begin
              code_d  = res_code;
              valid_d = 1'b1;
              held_d  = 1'b1;
              stab_d  = 4'd0;
              state_d = S_HELD;
            end else begin
              stab_d  = 4'd1;
              state_d = S_PRESS_CHK;
            end
          end
        end
        S_PRESS_CHK: begin
          if (res_hit && (res_code == cand_q)) begin
            if (stab_inc == DEB) begin
              code_d  = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
              stab_d  = 4'd0;
              state_d = S_HELD;
            end else begin
              stab_d = stab_inc;
            end
          end else if (res_hit) begin
            // A different key restarts the count on the new candidate.
            cand_d = res_code;
            stab_d = 4'd1;
          end else begin
            stab_d  = 4'd0;
            state_d = S_IDLE;
          end
        end
        S_HELD: begin
          // Any key while held is ignored: no auto-repeat, no roll-over.
          if (!res_hit) begin
            if (DEB == 4'd1) begin
              held_d  = 1'b0;
              stab_d  = 4'd0;
              state_d = S_IDLE;
            end else begin
              stab_d  = 4'd1;
              state_d = S_REL_CHK;
            end
          end
        end
        S_REL_CHK: begin
          if (!res_hit) begin
            if (stab_inc == DEB) begin
              held_d  = 1'b0;
              stab_d  = 4'd0;
              state_d = S_IDLE;
            end else begin
              stab_d = stab_inc;
            end
          end else begin
            stab_d  = 4'd0;
            state_d = S_HELD;
          end
        end
        default: begin
          stab_d  = 4'd0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Purpose : self-checking bench for key_matrix_scan with a frame-level model.
// Latency : frames of 4*SCAN_DIV cycles; outputs checked after each frame end.
// Backpressure: none; stimulus changes only on frame boundaries.
module tb_key_matrix_scan;

  localparam int SD    = 4;
  localparam int DB    = 3;
  localparam int FRAME = 4 * SD;
  localparam int NONE  = -1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] key_in;
  logic [3:0] key_out;
  logic [4:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [23:0] pressed = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;
  int frame_no = 0;

  // Frame-level reference: run length of identical frame results.
  bit m_held;
  int m_code;
  int m_run_val;
  int m_run_len;

  key_matrix_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .key_out  (key_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Matrix: column c pulled low when its key on the driven row is pressed.
  always_comb begin
    key_in = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 6; c++)
        if (key_out[r] === 1'b0 && pressed[r*6+c]) key_in[c] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (frame %0d): got %0d expected %0d", tag, frame_no, act, exp);
    end
  endtask

  function automatic int frame_result(input logic [23:0] p);
    for (int i = 0; i < 24; i++)
      if (p[i]) return i;
    return NONE;
  endfunction

  task automatic model_reset();
    m_held    = 1'b0;
    m_code    = 0;
    m_run_val = NONE;
    m_run_len = 0;
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_key_out", key_out, 4'b1110);
      chk("rst_valid", key_valid, 0);
      chk("rst_held", key_held, 0);
      chk("rst_code", key_code, 0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  // Runs one aligned frame with the current pressed set; call at a negedge
  // just after reset release or a previous frame end.
  task automatic run_frame();
    int         res;
    int         stray;
    int         exp_pulse;
    logic       at_end;
    logic [3:0] exp_ko;
    res       = frame_result(pressed);
    stray     = 0;
    exp_pulse = 0;
    at_end    = 1'b0;
    frame_no++;
    if (m_run_len > 0 && res == m_run_val) m_run_len++;
    else begin
      m_run_val = res;
      m_run_len = 1;
    end
    if (!m_held && res != NONE && m_run_len >= DB) begin
      exp_pulse = 1;
      m_held    = 1'b1;
      m_code    = res;
      m_run_len = 0;
    end else if (m_held && res == NONE && m_run_len >= DB) begin
      m_held    = 1'b0;
      m_run_len = 0;
    end
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (key_valid === 1'b1) begin
        pulses++;
        if (i == FRAME) at_end = 1'b1;
        else stray++;
      end
      exp_ko = 4'b0001 << ((i / SD) % 4);
      exp_ko = ~exp_ko;
      chk("key_out", key_out, exp_ko);
    end
    chk("valid_at_frame_end", at_end, exp_pulse);
    chk("valid_stray", stray, 0);
    chk("key_held", key_held, m_held);
    chk("key_code", key_code, m_code);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) run_frame();
  endtask

  int p0;

  initial begin
    model_reset();
    pressed = '0;

    // Reset and idle
    do_reset(3);
    chk("key_out_at_release", key_out, 4'b1110);
    p0 = pulses;
    frames(20);
    chk("idle_pulses", pulses - p0, 0);

    // Single press (1,4) then release
    p0 = pulses;
    pressed = '0; pressed[10] = 1'b1;
    frames(5);
    chk("single_held_while_pressed", key_held, 1);
    pressed = '0;
    frames(2);
    chk("single_held_after_2_none", key_held, 1);
    frames(2);
    chk("single_pulses", pulses - p0, 1);
    chk("single_code", key_code, 10);
    chk("single_released", key_held, 0);

    // Bounce on (2,0)
    p0 = pulses;
    for (int k = 0; k < 8; k++) begin
      pressed = '0;
      if (k % 2 == 0) pressed[12] = 1'b1;
      run_frame();
    end
    chk("bounce_pulses", pulses - p0, 0);
    chk("bounce_code_kept", key_code, 10);

    // Multi-key priority (3,5)+(0,2), then add (1,0)
    p0 = pulses;
    pressed = '0; pressed[23] = 1'b1; pressed[2] = 1'b1;
    frames(4);
    pressed[6] = 1'b1;
    frames(3);
    chk("multi_pulses", pulses - p0, 1);
    chk("multi_code", key_code, 2);
    pressed = '0;
    frames(4);

    // Boundary code (3,5)
    p0 = pulses;
    pressed = '0; pressed[23] = 1'b1;
    frames(4);
    chk("boundary_code", key_code, 23);
    chk("boundary_pulses", pulses - p0, 1);
    pressed = '0;
    frames(4);

    // Reset mid-debounce on (0,0), reset lands at a random point mid-frame
    pressed = '0; pressed[0] = 1'b1;
    frames(2);
    for (int i = 0; i < int'($urandom_range(1, FRAME - 1)); i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    do_reset(1);
    p0 = pulses;
    frames(2);
    chk("rst_mid_no_early_pulse", pulses - p0, 0);
    frames(1);
    chk("rst_mid_pulse_after_3", pulses - p0, 1);
    chk("rst_mid_code", key_code, 0);
    pressed = '0;
    frames(4);

    // Randomized key patterns held for random stretches
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 2) == 0) begin
        pressed = '0;
        for (int j = 0; j < int'($urandom_range(0, 2)); j++)
          pressed[$urandom_range(0, 23)] = 1'b1;
      end
      run_frame();
    end
    pressed = '0;
    frames(4);
    chk("final_released", key_held, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
